// File: rtl/conv_window_buffer.sv
// Sliding 3x3 window generator: pops raster-order pixels from a one-cycle-latency FIFO,
// keeps two line buffers and presents each full neighbourhood over valid/ready.
module conv_window_buffer #(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     i_sys_clk,
  input  logic                     i_rst,
  input  logic                     i_feature_valid,
  input  logic [DATA_W-1:0]        i_feature,
  output logic                     o_rd_en,
  output logic [9*DATA_W-1:0]      o_window,
  output logic                     o_window_valid,
  input  logic                     i_window_ready,
  output logic [$clog2(IMG_H)-1:0] o_row,
  output logic [$clog2(IMG_W)-1:0] o_col,
  output logic                     o_frame_done
);

  localparam int unsigned RowW = $clog2(IMG_H);
  localparam int unsigned ColW = $clog2(IMG_W);
  localparam logic [RowW-1:0] LastRow = RowW'(IMG_H - 1);
  localparam logic [ColW-1:0] LastCol = ColW'(IMG_W - 1);

  logic              rd_pend_q, rd_pend_d;
  logic              skid_full_q, skid_full_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   win_row_q, win_row_d;
  logic [ColW-1:0]   win_col_q, win_col_d;
  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;
  // Taps in row-major order: index 0 is top-left, index 8 is bottom-right.
  logic [DATA_W-1:0] win_q [9];
  logic [DATA_W-1:0] win_d [9];

  // lb1 holds the older of the two buffered rows.
  logic [DATA_W-1:0] lb0_q [IMG_W];
  logic [DATA_W-1:0] lb1_q [IMG_W];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  logic              accept;
  logic              consume;
  logic [DATA_W-1:0] pix;

  always_comb begin
    accept  = ~win_valid_q | i_window_ready;
    o_rd_en = i_feature_valid & accept & ~skid_full_q & ~i_rst;
    consume = accept & (skid_full_q | rd_pend_q);
    pix     = skid_full_q ? skid_q : i_feature;
    lb0_rd  = lb0_q[col_q];
    lb1_rd  = lb1_q[col_q];
  end

  always_comb begin
    rd_pend_d    = o_rd_en;
    skid_full_d  = skid_full_q;
    skid_d       = skid_q;
    row_d        = row_q;
    col_d        = col_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    win_valid_d  = win_valid_q;
    frame_done_d = 1'b0;
    win_d        = win_q;

    // A pixel landing while the consumer is stalled is parked in the skid.
    if (rd_pend_q && !accept) begin
      skid_full_d = 1'b1;
      skid_d      = i_feature;
    end else if (consume && skid_full_q) begin
      skid_full_d = 1'b0;
    end

    if (consume) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r+1];
        win_d[3*r + 1] = win_q[3*r+2];
      end
      win_d[2]    = lb1_rd;
      win_d[5]    = lb0_rd;
      win_d[8]    = pix;
      win_row_d   = row_q;
      win_col_d   = col_q;
      win_valid_d = (row_q >= RowW'(2)) && (col_q >= ColW'(2));
      if (col_q == LastCol) begin
        col_d = '0;
        if (row_q == LastRow) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + RowW'(1);
        end
      end else begin
        col_d = col_q + ColW'(1);
      end
    end else if (i_window_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      rd_pend_q    <= 1'b0;
      skid_full_q  <= 1'b0;
      skid_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      rd_pend_q    <= rd_pend_d;
      skid_full_q  <= skid_full_d;
      skid_q       <= skid_d;
      row_q        <= row_d;
      col_q        <= col_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Line-buffer contents need no reset; stale columns are masked by the valid rule.
  always_ff @(posedge i_sys_clk) begin
    if (consume) begin
      lb1_q[col_q] <= lb0_rd;
      lb0_q[col_q] <= pix;
    end
  end

  always_comb begin
    o_window = '0;
    for (int i = 0; i < 9; i++) begin
      o_window[(8-i)*DATA_W +: DATA_W] = win_q[i];
    end
  end

  assign o_window_valid = win_valid_q;
  assign o_row          = win_row_q;
  assign o_col          = win_col_q;
  assign o_frame_done   = frame_done_q;

  // Only one pop is ever outstanding, so a new arrival can never meet a full skid.
  skid_no_overflow_a : assert property (@(posedge i_sys_clk) disable iff (i_rst)
    !(rd_pend_q && skid_full_q));

endmodule

// File: doc/conv_window_buffer.md
# conv_window_buffer

Sliding 3x3 window generator between the pixel FIFO and the first convolutional layer, single clock domain (system clock). Pops 8-bit pixels from the FIFO read port (standard mode, one-cycle read latency) in raster order and keeps the two previous image rows in line buffers. For every pixel at row ≥ 2 and column ≥ 2 it presents the full 3x3 neighbourhood to the conv layer over a valid/ready handshake. Frame boundaries are tracked by internal row and column counters.

## Interface
- IMG_W, 28, image width in pixels (≥ 3)
- IMG_H, 28, image height in pixels (≥ 3)
- DATA_W, 8, pixel width in bits

- i_sys_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_feature_valid  in  1  FIFO not-empty
- i_feature  in  DATA_W  FIFO read data, valid the cycle after o_rd_en
- o_rd_en  out  1  FIFO pop
- o_window  out  9*DATA_W  window, row-major; [71:64]=top-left (r-2,c-2), [7:0]=bottom-right (r,c)
- o_window_valid  out  1  window valid
- i_window_ready  in  1  conv layer accepts window
- o_row  out  $clog2(IMG_H)  row of bottom-right pixel of o_window
- o_col  out  $clog2(IMG_W)  column of bottom-right pixel of o_window
- o_frame_done  out  1  one-cycle pulse when last pixel of frame consumed

## Operation
- accept = ~o_window_valid | i_window_ready (combinational).
- o_rd_en = i_feature_valid & accept & ~skid_full (combinational). Never asserted during i_rst.
- arrive = rd_pend, a register set to o_rd_en each cycle; i_feature is sampled when arrive=1.
- Skid register: 1 entry, DATA_W bits. An arriving pixel while accept=0 goes to skid, skid_full←1. At most one pixel is in flight, so skid never overflows. If arrive=1 while skid_full=1, that is an assertion error.
- Consume, at most one pixel per cycle, only when accept=1. Skid pixel first, if skid_full; else the arriving pixel. Arrival and skid_full together cannot occur.
- On consume of pixel p at counters (row, col):
  - window shift: each row's taps shift left by one. New right column = {lb1[col], lb0[col], p}, where lb1 is the oldest row.
  - lb1[col]←lb0[col], lb0[col]←p. Line buffers are IMG_W deep, addressed by col; RAM or shift register is allowed.
  - o_row/o_col←row/col.
  - o_window_valid←(row ≥ 2 && col ≥ 2).
  - col increments and wraps at IMG_W-1, then row increments. At (IMG_H-1, IMG_W-1), row and col wrap to 0 and o_frame_done pulses next cycle.
- No consume and i_window_ready=1: o_window_valid←0.
- No consume and accept=0: all outputs hold.
- While o_window_valid=1 & i_window_ready=0, o_window, o_row and o_col are stable.
- Windows per frame: (IMG_H-2)*(IMG_W-2), i.e. 676 for 28x28.
- Columns 0..1 of each row hold stale data from the previous row. They are suppressed by the valid rule and need no clearing.

## Timing
- Reset values: o_rd_en=0, o_window_valid=0, o_window=0, o_row=0, o_col=0, o_frame_done=0. Internally rd_pend=0, skid_full=0, row=col=0. Line-buffer contents are don't-care.
- Reset mid-frame: any in-flight pixel is dropped and the next frame starts at (0,0). The FIFO shares i_rst and is flushed at the same time.
- Latency: o_rd_en at cycle t, then pixel arrives at t+1. If accept=1 at t+1, the window, o_window_valid and counters update at the t+2 edge.
- Throughput: 1 pixel/cycle with continuous FIFO data and i_window_ready=1.
- After a stall releases with skid_full=1: the skid pixel is consumed in the release cycle and o_rd_en resumes the following cycle. This is a one-cycle read bubble.
- FIFO empty (i_feature_valid=0): no pops. Window state holds apart from valid dropping on handshake.

## Test plan
- Ramp frame 28x28 with p=(28r+c) mod 256, ready held 1: 676 windows, no gaps within a row. The first window has o_row=2, o_col=2 and o_window = {0,1,2,28,29,30,56,57,58}. o_frame_done pulses once after pixel 783.
- Back-pressure: ready=0 for 10 cycles mid-row. o_window and o_row/o_col are stable, exactly one pixel lands in skid, and o_rd_en=0 during the stall. On release the sequence continues with no lost or duplicated pixel; check against a reference model.
- FIFO starvation: i_feature_valid toggles at random 50%. Window contents and count match the model, with no windows while empty.
- Two back-to-back frames: second frame's first window is (2,2) with that frame's data. Exactly two o_frame_done pulses.
- Reset at pixel 400 with a pixel in flight: all outputs go to 0 next cycle and the following frame produces 676 correct windows.
- Random ready plus random FIFO-empty over 3 frames: scoreboard matches exactly, the skid never overflows, and o_rd_en is never high when i_feature_valid=0.
